// File: rtl/delivery_sequencer.sv
// -----------------------------------------------------------------------------
// delivery_sequencer
//
// Mission controller for the delivery robot. It selects the colour the detect
// datapath looks for (the table colour on the outbound leg, white on the
// return leg). It samples the per-frame direction verdict and debounces it
// over CONFIRM_FRAMES frames. It converts the verdict into motor commands.
// It also parks at the table for DWELL_CYCLES cycles before heading back.
//
// Optional build macro: DELIVERY_SEEK_ALT_EN
//   When defined, the SEEK turn direction sweeps between TURN_R and TURN_L.
//   It changes every SCAN_TIMEOUT_FRAMES/4 frames and starts with TURN_R on
//   each SEEK entry. The timeout to FAULT is the same in both builds.
//   When undefined, SEEK always turns right.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   start        in   one-cycle pulse, begins a mission (ignored while busy)
//   abort        in   one-cycle pulse, cancels the mission or clears FAULT
//   table_sel    in   [1:0] target table: 0 red, 1 green, 2 blue, 3 invalid
//   frame_done   in   one-cycle pulse, operate_mode valid on this cycle
//   operate_mode in   [2:0] 100 LEFT, 010 MIDDLE, 001 RIGHT, else NONE
//   arrived      in   proximity sensor level
//   color_mode   out  [1:0] 0 red, 1 green, 2 blue, 3 white
//   motor_cmd    out  [1:0] 00 STOP, 01 FWD, 10 TURN_L, 11 TURN_R
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on mission completion
//   fault        out  high while in FAULT
// -----------------------------------------------------------------------------
module delivery_sequencer #(
    parameter int CONFIRM_FRAMES      = 3,
    parameter int SCAN_TIMEOUT_FRAMES = 60,
    parameter int DWELL_CYCLES        = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] table_sel,
    input  logic       frame_done,
    input  logic [2:0] operate_mode,
    input  logic       arrived,
    output logic [1:0] color_mode,
    output logic [1:0] motor_cmd,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_TRACK,
        S_DWELL,
        S_FAULT
    } state_t;

    localparam logic [1:0] M_STOP      = 2'b00;
    localparam logic [1:0] M_FWD       = 2'b01;
    localparam logic [1:0] M_TURN_L    = 2'b10;
    localparam logic [1:0] M_TURN_R    = 2'b11;
    localparam logic [1:0] COLOR_WHITE = 2'd3;

    localparam int HIT_W   = $clog2(CONFIRM_FRAMES + 1);
    localparam int FRAME_W = $clog2(SCAN_TIMEOUT_FRAMES + 1);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [HIT_W-1:0]   HIT_MAX   = HIT_W'(CONFIRM_FRAMES);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(SCAN_TIMEOUT_FRAMES);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES);

    state_t             state_reg;
    logic               leg_reg;        // 0 outbound, 1 return
    logic [HIT_W-1:0]   hit_cnt_reg;
    logic [HIT_W-1:0]   lost_cnt_reg;
    logic [FRAME_W-1:0] frame_cnt_reg;
    logic [DWELL_W-1:0] dwell_cnt_reg;
    logic [1:0]         last_dir_reg;

    // Verdict decode: anything other than a clean one-hot counts as NONE.
    logic       verdict_valid;
    logic [1:0] verdict_cmd;

    always_comb begin
        verdict_valid = 1'b1;
        verdict_cmd   = M_STOP;
        case (operate_mode)
            3'b100:  verdict_cmd   = M_TURN_L;
            3'b010:  verdict_cmd   = M_FWD;
            3'b001:  verdict_cmd   = M_TURN_R;
            default: verdict_valid = 1'b0;
        endcase
    end

    // Saturating next values. Each threshold test is done on the incremented
    // value, so the transition fires on the frame/cycle that reaches the limit.
    logic [HIT_W-1:0]   hit_next;
    logic [HIT_W-1:0]   lost_next;
    logic [FRAME_W-1:0] frame_next;
    logic [DWELL_W-1:0] dwell_next;

    always_comb begin
        hit_next   = '0;
        if (verdict_valid) begin
            hit_next = (hit_cnt_reg == HIT_MAX) ? HIT_MAX : hit_cnt_reg + HIT_W'(1);
        end
        lost_next  = (lost_cnt_reg == HIT_MAX) ? HIT_MAX : lost_cnt_reg + HIT_W'(1);
        frame_next = (frame_cnt_reg == FRAME_MAX) ? FRAME_MAX : frame_cnt_reg + FRAME_W'(1);
        dwell_next = (dwell_cnt_reg == DWELL_MAX) ? DWELL_MAX : dwell_cnt_reg + DWELL_W'(1);
    end

    logic acquired;
    logic timed_out;
    logic lost_target;
    logic dwell_over;

    assign acquired    = (hit_next == HIT_MAX);
    assign timed_out   = (frame_next == FRAME_MAX);
    assign lost_target = (lost_next == HIT_MAX);
    assign dwell_over  = (dwell_next == DWELL_MAX);

`ifdef DELIVERY_SEEK_ALT_EN
    localparam int SWEEP_FRAMES = (SCAN_TIMEOUT_FRAMES / 4 > 0) ? SCAN_TIMEOUT_FRAMES / 4 : 1;
    localparam int SWEEP_W      = $clog2(SWEEP_FRAMES + 1);
    localparam logic [SWEEP_W-1:0] SWEEP_MAX = SWEEP_W'(SWEEP_FRAMES);

    logic [SWEEP_W-1:0] sweep_cnt_reg;
    logic               sweep_left_reg;
    logic [SWEEP_W-1:0] sweep_next;

    assign sweep_next = sweep_cnt_reg + SWEEP_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            leg_reg       <= 1'b0;
            hit_cnt_reg   <= '0;
            lost_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
            dwell_cnt_reg <= '0;
            last_dir_reg  <= M_STOP;
            color_mode    <= COLOR_WHITE;
            motor_cmd     <= M_STOP;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
`ifdef DELIVERY_SEEK_ALT_EN
            sweep_cnt_reg  <= '0;
            sweep_left_reg <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

`ifdef DELIVERY_SEEK_ALT_EN
            // Holding the sweep cleared outside SEEK makes every entry
            // start with a fresh right-turn phase.
            if (state_reg != S_SEEK) begin
                sweep_cnt_reg  <= '0;
                sweep_left_reg <= 1'b0;
            end
`endif

            if (abort) begin
                state_reg     <= S_IDLE;
                motor_cmd     <= M_STOP;
                busy          <= 1'b0;
                fault         <= 1'b0;
                hit_cnt_reg   <= '0;
                lost_cnt_reg  <= '0;
                frame_cnt_reg <= '0;
                dwell_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start && table_sel != 2'd3) begin
                            state_reg     <= S_SEEK;
                            color_mode    <= table_sel;
                            leg_reg       <= 1'b0;
                            hit_cnt_reg   <= '0;
                            lost_cnt_reg  <= '0;
                            frame_cnt_reg <= '0;
                            dwell_cnt_reg <= '0;
                            motor_cmd     <= M_TURN_R;
                            busy          <= 1'b1;
                        end
                    end

                    S_SEEK: begin
                        if (frame_done) begin
                            // Acquisition is tested first so it wins a tie
                            // with the scan timeout.
                            if (acquired) begin
                                state_reg     <= S_TRACK;
                                hit_cnt_reg   <= '0;
                                lost_cnt_reg  <= '0;
                                frame_cnt_reg <= '0;
                                motor_cmd     <= verdict_cmd;
                                last_dir_reg  <= verdict_cmd;
                            end else if (timed_out) begin
                                state_reg     <= S_FAULT;
                                hit_cnt_reg   <= '0;
                                lost_cnt_reg  <= '0;
                                frame_cnt_reg <= '0;
                                motor_cmd     <= M_STOP;
                                fault         <= 1'b1;
                            end else begin
                                hit_cnt_reg   <= hit_next;
                                frame_cnt_reg <= frame_next;
`ifdef DELIVERY_SEEK_ALT_EN
                                if (sweep_next == SWEEP_MAX) begin
                                    sweep_cnt_reg  <= '0;
                                    sweep_left_reg <= ~sweep_left_reg;
                                    motor_cmd      <= sweep_left_reg ? M_TURN_R : M_TURN_L;
                                end else begin
                                    sweep_cnt_reg  <= sweep_next;
                                end
`endif
                            end
                        end
                    end

                    S_TRACK: begin
                        // arrived is a level checked every cycle and beats a
                        // coincident frame verdict.
                        if (arrived) begin
                            motor_cmd     <= M_STOP;
                            hit_cnt_reg   <= '0;
                            lost_cnt_reg  <= '0;
                            frame_cnt_reg <= '0;
                            dwell_cnt_reg <= '0;
                            if (!leg_reg) begin
                                state_reg <= S_DWELL;
                            end else begin
                                state_reg <= S_IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end
                        end else if (frame_done) begin
                            if (verdict_valid) begin
                                motor_cmd    <= verdict_cmd;
                                last_dir_reg <= verdict_cmd;
                                lost_cnt_reg <= '0;
                            end else if (lost_target) begin
                                state_reg     <= S_SEEK;
                                hit_cnt_reg   <= '0;
                                lost_cnt_reg  <= '0;
                                frame_cnt_reg <= '0;
                                motor_cmd     <= M_TURN_R;
                            end else begin
                                lost_cnt_reg <= lost_next;
                                motor_cmd    <= last_dir_reg;
                            end
                        end
                    end

                    S_DWELL: begin
                        if (dwell_over) begin
                            state_reg     <= S_SEEK;
                            leg_reg       <= 1'b1;
                            color_mode    <= COLOR_WHITE;
                            dwell_cnt_reg <= '0;
                            motor_cmd     <= M_TURN_R;
                        end else begin
                            dwell_cnt_reg <= dwell_next;
                        end
                    end

                    S_FAULT: begin
                        motor_cmd <= M_STOP;
                        fault     <= 1'b1;
                        busy      <= 1'b1;
                    end

                    default: begin
                        state_reg <= S_IDLE;
                        motor_cmd <= M_STOP;
                        busy      <= 1'b0;
                        fault     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delivery_sequencer.sv
// -----------------------------------------------------------------------------
// tb_delivery_sequencer
//
// Scoreboard bench for delivery_sequencer (CONFIRM_FRAMES=3,
// SCAN_TIMEOUT_FRAMES=8, DWELL_CYCLES=10). Every driven transaction pushes
// the expected output vector {color_mode, motor_cmd, busy, done, fault} to a
// queue. That entry is popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_delivery_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] table_sel = 2'd0;
    logic       frame_done = 1'b0;
    logic [2:0] operate_mode = 3'b000;
    logic       arrived = 1'b0;
    logic [1:0] color_mode;
    logic [1:0] motor_cmd;
    logic       busy;
    logic       done;
    logic       fault;

    delivery_sequencer #(
        .CONFIRM_FRAMES     (3),
        .SCAN_TIMEOUT_FRAMES(8),
        .DWELL_CYCLES       (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .table_sel   (table_sel),
        .frame_done  (frame_done),
        .operate_mode(operate_mode),
        .arrived     (arrived),
        .color_mode  (color_mode),
        .motor_cmd   (motor_cmd),
        .busy        (busy),
        .done        (done),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] ev(input logic [1:0] c, input logic [1:0] m,
                                      input logic b, input logic d, input logic f);
        return {c, m, b, d, f};
    endfunction

    // One transaction: inputs are already driven, expectation is queued,
    // the DUT is clocked, and the result is compared 1 ns after the edge.
    task automatic step(input string tag, input logic [6:0] exp_v);
        logic [6:0] e;
        string      t;
        tag_q.push_back(tag);
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        $display("[%0t] %s: out=%07b exp=%07b", $time, t, {color_mode, motor_cmd, busy, done, fault}, e);
        check_val(t, {25'd0, color_mode, motor_cmd, busy, done, fault}, {25'd0, e});
    endtask

    task automatic frame(input string tag, input logic [2:0] mode, input logic [6:0] exp_v);
        operate_mode = mode;
        frame_done   = 1'b1;
        step(tag, exp_v);
        frame_done   = 1'b0;
        operate_mode = 3'b000;
    endtask

    task automatic pulse_start(input string tag, input logic [1:0] sel, input logic [6:0] exp_v);
        table_sel = sel;
        start     = 1'b1;
        step(tag, exp_v);
        start     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset
        step("reset_a", ev(2'd3, 2'b00, 0, 0, 0));
        step("reset_b", ev(2'd3, 2'b00, 0, 0, 0));
        reset = 1'b0;

        // 1: start green, acquire on three MIDDLE frames
        pulse_start("start_g", 2'd1, ev(2'd1, 2'b11, 1, 0, 0));
        frame("seek_m1", 3'b010, ev(2'd1, 2'b11, 1, 0, 0));
        frame("seek_m2", 3'b010, ev(2'd1, 2'b11, 1, 0, 0));
        frame("acq_fwd", 3'b010, ev(2'd1, 2'b01, 1, 0, 0));

        // 2: tracking steer, then lose the target
        frame("trk_left",  3'b100, ev(2'd1, 2'b10, 1, 0, 0));
        frame("trk_right", 3'b001, ev(2'd1, 2'b11, 1, 0, 0));
        frame("lost1",     3'b000, ev(2'd1, 2'b11, 1, 0, 0));
        frame("lost2",     3'b111, ev(2'd1, 2'b11, 1, 0, 0));
        frame("lost3",     3'b000, ev(2'd1, 2'b11, 1, 0, 0));

        // 3: back in SEEK, LEFT verdict needs three frames before steering
        frame("reseek1", 3'b100, ev(2'd1, 2'b11, 1, 0, 0));
        frame("reseek2", 3'b100, ev(2'd1, 2'b11, 1, 0, 0));
        frame("reacq_l", 3'b100, ev(2'd1, 2'b10, 1, 0, 0));
        arrived = 1'b1;
        step("arrive_out", ev(2'd1, 2'b00, 1, 0, 0));
        arrived = 1'b0;
        n = 0;
        while (color_mode != 2'd3 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("dwell_len", n, 10);
        check_val("return_seek", {25'd0, color_mode, motor_cmd, busy, done, fault},
                  {25'd0, ev(2'd3, 2'b11, 1, 0, 0)});
        frame("ret_m1",  3'b010, ev(2'd3, 2'b11, 1, 0, 0));
        frame("ret_m2",  3'b010, ev(2'd3, 2'b11, 1, 0, 0));
        frame("ret_acq", 3'b010, ev(2'd3, 2'b01, 1, 0, 0));
        arrived = 1'b1;
        step("arrive_home", ev(2'd3, 2'b00, 0, 1, 0));
        arrived = 1'b0;
        step("done_1cyc", ev(2'd3, 2'b00, 0, 0, 0));

        // 4: scan timeout into FAULT
        pulse_start("start_b", 2'd2, ev(2'd2, 2'b11, 1, 0, 0));
        for (int i = 0; i < 7; i++) begin
            frame($sformatf("scan%0d", i + 1), (i % 2 == 0) ? 3'b010 : 3'b000,
                  ev(2'd2, 2'b11, 1, 0, 0));
        end
        frame("timeout", 3'b000, ev(2'd2, 2'b00, 1, 0, 1));
        pulse_start("fault_start", 2'd0, ev(2'd2, 2'b00, 1, 0, 1));
        abort = 1'b1;
        step("fault_abort", ev(2'd2, 2'b00, 0, 0, 0));
        abort = 1'b0;

        // 5: arrived beats a coincident LEFT frame
        pulse_start("start_r", 2'd0, ev(2'd0, 2'b11, 1, 0, 0));
        frame("r_m1",  3'b010, ev(2'd0, 2'b11, 1, 0, 0));
        frame("r_m2",  3'b010, ev(2'd0, 2'b11, 1, 0, 0));
        frame("r_acq", 3'b010, ev(2'd0, 2'b01, 1, 0, 0));
        arrived = 1'b1;
        frame("arrive_prio", 3'b100, ev(2'd0, 2'b00, 1, 0, 0));
        arrived = 1'b0;
        frame("dwell_ignore", 3'b100, ev(2'd0, 2'b00, 1, 0, 0));

        // 6: abort mid-DWELL, then invalid table start in IDLE
        abort = 1'b1;
        step("dwell_abort", ev(2'd0, 2'b00, 0, 0, 0));
        abort = 1'b0;
        step("no_done", ev(2'd0, 2'b00, 0, 0, 0));
        pulse_start("bad_table", 2'd3, ev(2'd0, 2'b00, 0, 0, 0));

        // Reset mid-TRACK
        pulse_start("start_b2", 2'd2, ev(2'd2, 2'b11, 1, 0, 0));
        frame("b_l1",  3'b100, ev(2'd2, 2'b11, 1, 0, 0));
        frame("b_l2",  3'b100, ev(2'd2, 2'b11, 1, 0, 0));
        frame("b_acq", 3'b100, ev(2'd2, 2'b10, 1, 0, 0));
        reset = 1'b1;
        step("mid_reset", ev(2'd3, 2'b00, 0, 0, 0));
        reset = 1'b0;
        frame("post_reset", 3'b010, ev(2'd3, 2'b00, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delivery_sequencer.md
Name: delivery_sequencer

Overview:
Mission controller for the delivery robot. It drives the colour-detect datapath's `color_mode` input: first the selected table colour, then white for the return to the kitchen. It samples the per-frame `operate_mode` verdict once per frame, debounces it over several frames, and turns it into motor commands. It sits between the camera detect block, the motor driver and the top-level user controls.

Parameters:
- CONFIRM_FRAMES, 3: consecutive frames with the same verdict class needed to acquire or lose the target.
- SCAN_TIMEOUT_FRAMES, 60: frames spent in SEEK without acquiring the target before FAULT.
- DWELL_CYCLES, 50000000: clk cycles stopped at the table (1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a mission
- abort  in  1  one-cycle pulse; cancels the mission or clears FAULT
- table_sel  in  2  target table: 0 red, 1 green, 2 blue; 3 is invalid
- frame_done  in  1  one-cycle pulse; asserts on the cycle `operate_mode` is valid for the completed frame
- operate_mode  in  3  detect verdict: 100 LEFT, 010 MIDDLE, 001 RIGHT, 000 NONE
- arrived  in  1  level from the proximity sensor
- color_mode  out  2  to the detect block: 0 red, 1 green, 2 blue, 3 white
- motor_cmd  out  2  00 STOP, 01 FWD, 10 TURN_L, 11 TURN_R
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on mission completion
- fault  out  1  high while in FAULT

Behaviour:
- All outputs are registered. Reset values: color_mode=3, motor_cmd=STOP, busy=0, done=0, fault=0. Reset also clears state, leg, all counters and the last-direction register.
- leg register: 0 = outbound, 1 = return.
- Sampling rule: `operate_mode` is only consulted on cycles where frame_done=1. Any value other than 100, 010, 001 counts as NONE.
- A frame_done-driven decision changes motor_cmd on the next cycle (1-cycle latency).
- States: IDLE, SEEK, TRACK, DWELL, FAULT.
- IDLE:
  - motor STOP.
  - start with table_sel≠3: latch color_mode=table_sel, leg=0, clear counters, go to SEEK.
  - start with table_sel=3: ignored; remain IDLE.
- SEEK:
  - motor TURN_R.
  - Each frame: a non-NONE verdict increments hit_cnt; NONE resets hit_cnt to 0. Every frame increments frame_cnt.
  - hit_cnt reaching CONFIRM_FRAMES: go to TRACK, clear counters, and apply the mapping for that frame's verdict.
  - Otherwise, frame_cnt reaching SCAN_TIMEOUT_FRAMES: go to FAULT. Acquisition wins if both occur on the same frame.
- TRACK:
  - Per frame: LEFT → TURN_L, MIDDLE → FWD, RIGHT → TURN_R; the direction is remembered and lost_cnt is cleared.
  - NONE: hold the last command and increment lost_cnt. lost_cnt reaching CONFIRM_FRAMES: go to SEEK, clear counters.
  - arrived=1 (checked every cycle, not only on frame_done): motor STOP next cycle.
    - leg=0: go to DWELL, clear the cycle counter.
    - leg=1: go to IDLE and pulse done for 1 cycle.
  - arrived has priority over a frame_done on the same cycle.
- DWELL:
  - motor STOP; frame_done is ignored.
  - After DWELL_CYCLES cycles in DWELL: leg=1, color_mode=3, go to SEEK.
  - arrived staying high is ignored.
- FAULT: motor STOP, fault=1, busy=1. Only abort or reset exits; start is ignored.
- Priority: reset > abort > all other events.
  - abort in any state: go to IDLE, motor STOP next cycle, counters cleared, fault cleared, no done pulse.
  - start while busy is ignored.
- color_mode holds its last value in IDLE; it changes only at a mission start or on the DWELL→SEEK transition.
- Counter widths: $clog2(param+1) bits. Counters saturate and never wrap.

Optional Feature:
- Macro: DELIVERY_SEEK_ALT_EN.
- Defined: the SEEK turn direction alternates between TURN_R and TURN_L every SCAN_TIMEOUT_FRAMES/4 frames, starting with TURN_R on each SEEK entry; this sweeps the camera back and forth. The timeout to FAULT is unchanged.
- Undefined: SEEK always commands TURN_R.

Test Plan:
Bench parameters: CONFIRM_FRAMES=3, SCAN_TIMEOUT_FRAMES=8, DWELL_CYCLES=10.
1. Reset, then start with table_sel=1 → color_mode=1, busy=1, motor_cmd=11. Three frames of 010 → TRACK, with motor_cmd=01 on the cycle after the third frame_done.
2. In TRACK: frame 100 → motor_cmd=10; frame 001 → motor_cmd=11; two NONE frames → 11 held; third NONE → SEEK, motor_cmd=11.
3. arrived=1 with leg=0 → motor_cmd=00 next cycle; after 10 cycles color_mode=3 and motor_cmd=11. Reacquire three frames, then arrived=1 → done pulses exactly 1 cycle, busy=0.
4. In SEEK, 8 frames alternating 010/000 → fault=1, motor_cmd=00. start is ignored; abort → fault=0, busy=0.
5. Same cycle as a frame_done carrying 100 in TRACK, assert arrived → DWELL and motor_cmd=00, not 10. start with table_sel=3 in IDLE → busy stays 0.
6. abort mid-DWELL → IDLE, motor_cmd=00, no done pulse, color_mode held at the table colour. Reset asserted mid-TRACK → all outputs return to their reset values the next cycle.
